// File: rtl/dmem_chk_pkg.sv
// Shared types, parameters and index decode for the data-memory result checker.
// The class map mirrors the test program layout in data memory.
package dmem_chk_pkg;

  localparam int          NOP_TIMEOUT = 9;
  localparam int          WATCHDOG    = 500;
  localparam int          NUM_WORDS   = 75;
  localparam int          NUM_CLASSES = 11;
  localparam logic [31:0] REF_OFFSET  = 32'h0000_3000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    LDST = 4'd0,
    ADD  = 4'd1,
    ADDI = 4'd2,
    SUB  = 4'd3,
    SLT  = 4'd4,
    SLTI = 4'd5,
    BEQ  = 4'd6,
    BNE  = 4'd7,
    JUMP = 4'd8,
    JAL  = 4'd9,
    JR   = 4'd10,
    NONE = 4'd15
  } class_e;

  function automatic class_e idx2class(input logic [6:0] idx);
    class_e c;
    case (idx)
      7'd3, 7'd4, 7'd6:                                   c = LDST;
      7'd7, 7'd8, 7'd9, 7'd10:                            c = ADD;
      7'd48, 7'd49, 7'd50, 7'd51, 7'd52:                  c = ADDI;
      7'd15, 7'd16, 7'd17, 7'd18:                         c = SUB;
      7'd19, 7'd20:                                       c = SLT;
      7'd43, 7'd44, 7'd45, 7'd46, 7'd47:                  c = SLTI;
      7'd11, 7'd12, 7'd13, 7'd14, 7'd21, 7'd57, 7'd58:    c = BEQ;
      7'd22, 7'd23, 7'd24, 7'd25, 7'd26:                  c = BNE;
      7'd27, 7'd28, 7'd29, 7'd30, 7'd31, 7'd59, 7'd60:    c = JUMP;
      7'd32, 7'd33, 7'd34, 7'd35, 7'd36, 7'd37, 7'd38,
      7'd40, 7'd41, 7'd42:                                c = JAL;
      7'd39, 7'd53, 7'd54, 7'd55, 7'd56:                  c = JR;
      default:                                            c = NONE;
    endcase
    return c;
  endfunction

  // These words hold return addresses that land in memory with a fixed base.
  function automatic logic offset_idx(input logic [6:0] idx);
    return (idx == 7'd34) || (idx == 7'd38) || (idx == 7'd41) || (idx == 7'd52);
  endfunction

endpackage

// File: rtl/dmem_chk_tally.sv
// Per-class 4-bit pass counters with a combinational sum of all tallies.
module dmem_chk_tally
  import dmem_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_vld_i,
  input  logic [3:0]  inc_cls_i,
  output logic [43:0] pass_cnt_o,
  output logic [6:0]  total_pass_o
);

  logic [3:0] cnt_q [NUM_CLASSES];

  // NONE (15) never matches a counter slot, so it is silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= 4'd0;
    end else if (inc_vld_i) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (inc_cls_i == 4'(k)) cnt_q[k] <= cnt_q[k] + 4'd1;
      end
    end
  end

  always_comb begin
    pass_cnt_o   = '0;
    total_pass_o = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      pass_cnt_o[4*k +: 4] = cnt_q[k];
      total_pass_o         = total_pass_o + 7'(cnt_q[k]);
    end
  end

endmodule

// File: rtl/dmem_result_checker.sv
// Detects program end or watchdog expiry, halts the core, then scans data memory
// against a reference ROM and tallies matches per instruction class.
module dmem_result_checker
  import dmem_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic        cpu_halt,
  output logic [31:0] chk_addr,
  input  logic [31:0] chk_rdata,
  output logic [6:0]  ref_addr,
  input  logic [31:0] ref_data,
  output logic [43:0] pass_cnt,
  output logic [6:0]  total_pass,
  output logic        wdog_hit,
  output logic        done
);

  state_e      state_q, state_d;
  logic [3:0]  nop_q, nop_d;
  logic [8:0]  watch_q, watch_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  cmp_idx_q, cmp_idx_d;
  logic        cmp_vld_q, cmp_vld_d;
  logic        halt_q, halt_d;
  logic        wdog_q, wdog_d;
  logic        nop_hit, wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      nop_q     <= '0;
      watch_q   <= '0;
      idx_q     <= '0;
      cmp_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      halt_q    <= 1'b0;
      wdog_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nop_q     <= nop_d;
      watch_q   <= watch_d;
      idx_q     <= idx_d;
      cmp_idx_q <= cmp_idx_d;
      cmp_vld_q <= cmp_vld_d;
      halt_q    <= halt_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nop_d     = nop_q;
    watch_d   = watch_q;
    idx_d     = idx_q;
    cmp_idx_d = cmp_idx_q;
    cmp_vld_d = 1'b0;
    halt_d    = halt_q;
    wdog_d    = wdog_q;
    nop_hit   = 1'b0;
    wd_hit    = 1'b0;
    case (state_q)
      RUN: begin
        if (inst == 32'd0) nop_d = (nop_q == 4'hF) ? nop_q : nop_q + 4'd1;
        else               nop_d = 4'd0;
        watch_d = watch_q + 9'd1;
        nop_hit = (nop_d == 4'(NOP_TIMEOUT));
        wd_hit  = (watch_d == 9'(WATCHDOG));
        if (nop_hit || wd_hit) begin
          state_d = SCAN;
          halt_d  = 1'b1;
          wdog_d  = wd_hit;
          idx_d   = '0;
        end
      end
      SCAN: begin
        cmp_vld_d = 1'b1;
        cmp_idx_d = idx_q;
        if (idx_q == 7'(NUM_WORDS - 1)) state_d = DRAIN;
        else                            idx_d   = idx_q + 7'd1;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // Read data for the index issued last cycle is on chk_rdata/ref_data now.
  logic [31:0] exp_word;
  logic        cmp_match;

  assign exp_word  = ref_data - (offset_idx(cmp_idx_q) ? REF_OFFSET : 32'd0);
  assign cmp_match = cmp_vld_q && (chk_rdata == exp_word);

  dmem_chk_tally u_tally (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_vld_i    (cmp_match),
    .inc_cls_i    (idx2class(cmp_idx_q)),
    .pass_cnt_o   (pass_cnt),
    .total_pass_o (total_pass)
  );

  assign cpu_halt = halt_q;
  assign wdog_hit = wdog_q;
  assign done     = (state_q == DONE);
  assign chk_addr = {23'd0, idx_q, 2'b00};
  assign ref_addr = idx_q;

endmodule

// File: tb/tb_dmem_result_checker.sv
// Directed bench for dmem_result_checker with synchronous-read memory and ROM models.
module tb_dmem_result_checker;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        cpu_halt;
  logic [31:0] chk_addr;
  logic [31:0] chk_rdata;
  logic [6:0]  ref_addr;
  logic [31:0] ref_data;
  logic [43:0] pass_cnt;
  logic [6:0]  total_pass;
  logic        wdog_hit;
  logic        done;

  int total_chk = 0;
  int bad_chk   = 0;

  logic [31:0] mem     [0:127];
  logic [31:0] ref_rom [0:127];

  // LDST ADD ADDI SUB SLT SLTI BEQ BNE JUMP JAL JR
  int exp_cls [11] = '{3, 4, 5, 4, 2, 5, 7, 5, 7, 10, 5};

  localparam logic [31:0] BUSY_INST = 32'h2002_0005;

  dmem_result_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .cpu_halt   (cpu_halt),
    .chk_addr   (chk_addr),
    .chk_rdata  (chk_rdata),
    .ref_addr   (ref_addr),
    .ref_data   (ref_data),
    .pass_cnt   (pass_cnt),
    .total_pass (total_pass),
    .wdog_hit   (wdog_hit),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    chk_rdata <= mem[chk_addr[8:2]];
    ref_data  <= ref_rom[ref_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++) begin
      ref_rom[i] = 32'h1000_0000 + i * 32'h0001_1111;
      if (i == 34 || i == 38 || i == 41 || i == 52) mem[i] = ref_rom[i] - 32'h3000;
      else                                          mem[i] = ref_rom[i];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    inst  = BUSY_INST;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Reset, run a short program, then issue NOPs until the core is halted.
  task automatic start_scan();
    int n;
    apply_reset();
    repeat (20) tick();
    inst = 32'd0;
    n = 0;
    while (!cpu_halt && n < 20) begin
      tick();
      n++;
    end
    inst = BUSY_INST;
    total_chk++;
    if (cpu_halt !== 1'b1) begin
      bad_chk++;
      $display("FAIL start_halt: cpu_halt=%b required 1", cpu_halt);
    end
  endtask

  task automatic finish_scan();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    total_chk++;
    if (done !== 1'b1) begin
      bad_chk++;
      $display("FAIL scan_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total_chk++;
    if (cpu_halt !== 1'b0) begin bad_chk++; $display("FAIL reset_halt: got %b want 0", cpu_halt); end
    total_chk++;
    if (done !== 1'b0) begin bad_chk++; $display("FAIL reset_done: got %b want 0", done); end
    total_chk++;
    if (wdog_hit !== 1'b0) begin bad_chk++; $display("FAIL reset_wdog: got %b want 0", wdog_hit); end
    total_chk++;
    if (chk_addr !== 32'd0) begin bad_chk++; $display("FAIL reset_chk_addr: got %h want 0", chk_addr); end
    total_chk++;
    if (ref_addr !== 7'd0) begin bad_chk++; $display("FAIL reset_ref_addr: got %0d want 0", ref_addr); end
    total_chk++;
    if (pass_cnt !== 44'd0) begin bad_chk++; $display("FAIL reset_pass_cnt: got %h want 0", pass_cnt); end
    total_chk++;
    if (total_pass !== 7'd0) begin bad_chk++; $display("FAIL reset_total: got %0d want 0", total_pass); end
  endtask

  task automatic test_nop_end();
    apply_reset();
    repeat (20) tick();
    inst = 32'd0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total_chk++;
      if (cpu_halt !== (i == 9)) begin
        bad_chk++;
        $display("FAIL nop_halt_%0d: cpu_halt=%b want %b", i, cpu_halt, (i == 9));
      end
    end
    inst = BUSY_INST;
    total_chk++;
    if (wdog_hit !== 1'b0) begin bad_chk++; $display("FAIL nop_wdog: got %b want 0", wdog_hit); end
    for (int k = 1; k <= 76; k++) begin
      tick();
      if (k >= 75) begin
        total_chk++;
        if (done !== (k == 76)) begin
          bad_chk++;
          $display("FAIL nop_done_lat_%0d: done=%b want %b", k, done, (k == 76));
        end
      end
    end
  endtask

  task automatic test_full_match();
    for (int k = 0; k < 11; k++) begin
      total_chk++;
      if (pass_cnt[4*k +: 4] !== 4'(exp_cls[k])) begin
        bad_chk++;
        $display("FAIL full_class_%0d: got %0d want %0d", k, pass_cnt[4*k +: 4], exp_cls[k]);
      end
    end
    total_chk++;
    if (total_pass !== 7'd57) begin bad_chk++; $display("FAIL full_total: got %0d want 57", total_pass); end
    inst = 32'd0;
    repeat (5) tick();
    inst = BUSY_INST;
    total_chk++;
    if (done !== 1'b1 || total_pass !== 7'd57 || cpu_halt !== 1'b1) begin
      bad_chk++;
      $display("FAIL full_frozen: done=%b halt=%b total=%0d want 1 1 57", done, cpu_halt, total_pass);
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    repeat (100) tick();
    inst = 32'd0;
    repeat (8) tick();
    inst = BUSY_INST;
    tick();
    total_chk++;
    if (cpu_halt !== 1'b0) begin bad_chk++; $display("FAIL wd_8nop_halt: got %b want 0", cpu_halt); end
    repeat (390) tick();
    total_chk++;
    if (cpu_halt !== 1'b0) begin bad_chk++; $display("FAIL wd_499_halt: got %b want 0", cpu_halt); end
    tick();
    total_chk++;
    if (cpu_halt !== 1'b1) begin bad_chk++; $display("FAIL wd_500_halt: got %b want 1", cpu_halt); end
    total_chk++;
    if (wdog_hit !== 1'b1) begin bad_chk++; $display("FAIL wd_flag: got %b want 1", wdog_hit); end
    finish_scan();
    total_chk++;
    if (total_pass !== 7'd57) begin bad_chk++; $display("FAIL wd_total: got %0d want 57", total_pass); end
  endtask

  task automatic test_offset_corrupt();
    mem[34] = ref_rom[34];
    mem[21] = ref_rom[21] ^ 32'h0000_0001;
    start_scan();
    finish_scan();
    total_chk++;
    if (pass_cnt[39:36] !== 4'd9) begin bad_chk++; $display("FAIL corrupt_jal: got %0d want 9", pass_cnt[39:36]); end
    total_chk++;
    if (pass_cnt[27:24] !== 4'd6) begin bad_chk++; $display("FAIL corrupt_beq: got %0d want 6", pass_cnt[27:24]); end
    total_chk++;
    if (total_pass !== 7'd55) begin bad_chk++; $display("FAIL corrupt_total: got %0d want 55", total_pass); end
    load_mem();
  endtask

  task automatic test_reset_mid_scan();
    start_scan();
    repeat (40) tick();
    total_chk++;
    if (chk_addr !== 32'd160 || total_pass === 7'd0) begin
      bad_chk++;
      $display("FAIL mid_pre: chk_addr=%0d total=%0d want 160 and nonzero", chk_addr, total_pass);
    end
    rst_n = 1'b0;
    #1;
    total_chk++;
    if (cpu_halt !== 1'b0 || done !== 1'b0 || wdog_hit !== 1'b0) begin
      bad_chk++;
      $display("FAIL mid_flags: halt=%b done=%b wdog=%b want 0 0 0", cpu_halt, done, wdog_hit);
    end
    total_chk++;
    if (chk_addr !== 32'd0 || ref_addr !== 7'd0) begin
      bad_chk++;
      $display("FAIL mid_addr: chk_addr=%0d ref_addr=%0d want 0 0", chk_addr, ref_addr);
    end
    total_chk++;
    if (pass_cnt !== 44'd0 || total_pass !== 7'd0) begin
      bad_chk++;
      $display("FAIL mid_tally: pass_cnt=%h total=%0d want 0 0", pass_cnt, total_pass);
    end
    start_scan();
    finish_scan();
    total_chk++;
    if (total_pass !== 7'd57) begin bad_chk++; $display("FAIL mid_rerun_total: got %0d want 57", total_pass); end
  endtask

  task automatic test_scan_timing();
    int tot_want;
    mem[5] = ref_rom[5] ^ 32'h0000_FFFF;
    start_scan();
    for (int k = 0; k < 75; k++) begin
      total_chk++;
      if (chk_addr !== 32'(k * 4) || ref_addr !== 7'(k)) begin
        bad_chk++;
        $display("FAIL seq_addr_%0d: chk_addr=%0d ref_addr=%0d want %0d %0d", k, chk_addr, ref_addr, k * 4, k);
      end
      if (k >= 4 && k <= 6) begin
        tot_want = k - 4;
        total_chk++;
        if (total_pass !== 7'(tot_want)) begin
          bad_chk++;
          $display("FAIL seq_latency_%0d: total=%0d want %0d", k, total_pass, tot_want);
        end
      end
      tick();
    end
    total_chk++;
    if (done !== 1'b0) begin bad_chk++; $display("FAIL seq_drain: done=%b want 0", done); end
    tick();
    total_chk++;
    if (done !== 1'b1 || total_pass !== 7'd57) begin
      bad_chk++;
      $display("FAIL seq_end: done=%b total=%0d want 1 57", done, total_pass);
    end
    load_mem();
  endtask

  initial begin
    rst_n = 1'b0;
    inst  = BUSY_INST;
    load_mem();
    test_reset();
    test_nop_end();
    test_full_match();
    test_watchdog();
    test_offset_corrupt();
    test_reset_mid_scan();
    test_scan_timing();
    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
